// File: rtl/alu_pkg.sv
// alu_pkg: transform mode encodings shared by the operand stage and the control FSM
package alu_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_PASS = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SEXT = 3'b001;
  localparam logic [MODE_W-1:0] MODE_ZEXT = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHL2 = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SHLH = 3'b100;
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: upstream offer, downstream operand and status signals of the operand stage
interface alu_operand_stage_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
);
  logic flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [SEL_W-1:0] sel;
  logic [alu_pkg::MODE_W-1:0] mode;
  logic [NUM_SRC*WIDTH-1:0] src_flat;
  logic [WIDTH-1:0] out_data;
  modport master (output flush, in_valid, sel, mode, src_flat, out_ready,
                  input in_ready, out_valid, out_data, err);
  modport slave (input flush, in_valid, sel, mode, src_flat, out_ready,
                 output in_ready, out_valid, out_data, err);
endinterface

// File: rtl/operand_transform.sv
// operand_transform: selects one source slot and applies the extend/shift transform
module operand_transform import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [MODE_W-1:0]        mode,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  output logic [WIDTH-1:0]         data,
  output logic                     illegal
);
  localparam int H = WIDTH / 2;
  logic [WIDTH-1:0] x;
  logic sel_bad;
  // an unmatched select leaves x at zero, which every transform maps to zero
  always_comb begin
    x = '0;
    sel_bad = 1'b1;
    for (int k = 0; k < NUM_SRC; k++)
      if (sel == SEL_W'(k)) begin
        x = src_flat[k*WIDTH +: WIDTH];
        sel_bad = 1'b0;
      end
    data = mode == MODE_SEXT ? {{H{x[H-1]}}, x[H-1:0]} :
           mode == MODE_ZEXT ? {{H{1'b0}}, x[H-1:0]} :
           mode == MODE_SHL2 ? x << 2 :
           mode == MODE_SHLH ? {x[H-1:0], {H{1'b0}}} : x;
    illegal = sel_bad | (mode > MODE_SHLH);
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand mux + transform feeding a 2-entry valid/ready buffer with sticky err
module alu_operand_stage import alu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input logic clk,
  input logic reset_n,
  alu_operand_stage_if.slave bus
);
  logic [WIDTH-1:0] mem [2];
  logic [WIDTH-1:0] t_data;
  logic [1:0] count;
  logic head, tail, err_q, t_ill, acc, pop;
  operand_transform #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_xf (
    .sel(bus.sel), .mode(bus.mode), .src_flat(bus.src_flat), .data(t_data), .illegal(t_ill)
  );
  assign bus.in_ready  = count < 2'd2;
  assign bus.out_valid = count != 2'd0;
  assign bus.out_data  = bus.out_valid ? mem[head] : '0;
  assign bus.err       = err_q;
  assign acc = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  // flush outranks accept and pop, including the err update of an illegal accept
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem <= '{default: '0};
      count <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.flush) begin
      mem <= '{default: '0};
      count <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (acc) begin
        mem[tail] <= t_data;
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, acc} - {1'b0, pop};
      if (acc & t_ill) err_q <= 1'b1;
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: randomized scoreboard bench against a behavioural operand model
module tb_alu_operand_stage;
  localparam int NS = 3;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  alu_operand_stage_if #(.WIDTH(32), .NUM_SRC(NS)) bus ();
  alu_operand_stage #(.WIDTH(32), .NUM_SRC(NS)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  logic [31:0] src [NS];
  logic [31:0] q [$];
  logic exp_err = 0;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [32:0] ref_op(input int s, input int m);
    logic [31:0] x, r;
    x = (s < NS) ? src[s] : 32'd0;
    case (m)
      0: r = x;
      1: r = 32'(int'(shortint'(x[15:0])));
      2: r = x % 65536;
      3: r = x * 4;
      4: r = x * 65536;
      default: r = x;
    endcase
    return {(s >= NS) || (m > 4), r};
  endfunction
  // starts just after a rising edge, returns 1 time unit after the next one
  task automatic drive(input logic v, input logic [1:0] s, input logic [2:0] m,
                       input logic ordy, input logic fl, output logic acc);
    logic [32:0] e;
    bus.in_valid = v; bus.sel = s; bus.mode = m; bus.out_ready = ordy; bus.flush = fl;
    bus.src_flat = {src[2], src[1], src[0]};
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    e = ref_op(int'(s), int'(m));
    @(posedge clk);
    if (fl) begin q.delete(); exp_err = 0; end
    else if (acc) begin q.push_back(e[31:0]); if (e[32]) exp_err = 1; end
    #1;
  endtask
  always @(negedge clk) if (reset_n) begin
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("err", 32'(bus.err), 32'(exp_err));
    if (!bus.out_valid) chk("idle_data", bus.out_data, 32'd0);
    else if (q.size() != 0) chk("data", bus.out_data, q[0]);
    if (bus.out_valid && bus.out_ready && !bus.flush && q.size() != 0) void'(q.pop_front());
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic a;
    logic [2:0] mw [5];
    logic [31:0] want [5];
    mw = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    want = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_8001, 32'h0002_0004, 32'h8001_0000};
    foreach (src[i]) src[i] = $urandom;
    bus.in_valid = 1; bus.sel = 0; bus.mode = 0; bus.out_ready = 1; bus.flush = 0;
    bus.src_flat = {src[2], src[1], src[0]};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_err", 32'(bus.err), 0);
    reset_n = 1;
    #1 chk("rel_in_ready", 32'(bus.in_ready), 1);
    src[1] = 32'h0000_8001;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, mw[i], 1, 0, a);
      chk("xf_acc", 32'(a), 1);
      chk("xf_valid", 32'(bus.out_valid), 1);
      chk("xf_data", bus.out_data, want[i]);
    end
    repeat (2) drive(0, 0, 0, 1, 0, a);
    // back-pressure: fill with A,B then hold C until room appears
    src[0] = 32'hAAAA_0001; drive(1, 0, 0, 0, 0, a);
    src[0] = 32'hBBBB_0002; drive(1, 0, 0, 0, 0, a);
    chk("bp_full", 32'(bus.in_ready), 0);
    src[0] = 32'hCCCC_0003; drive(1, 0, 0, 0, 0, a);
    chk("bp_held", 32'(a), 0);
    a = 0;
    for (int i = 0; i < 5 && !a; i++) drive(1, 0, 0, 1, 0, a);
    chk("bp_c_taken", 32'(a), 1);
    repeat (3) drive(0, 0, 0, 1, 0, a);
    chk("bp_drained", 32'(bus.out_valid), 0);
    drive(1, 2, 0, 1, 0, a);
    for (int i = 0; i < 10; i++) begin
      foreach (src[j]) src[j] = $urandom;
      drive(1, 2'($urandom_range(0, NS - 1)), 3'($urandom_range(0, 4)), 1, 0, a);
      chk("tp_acc", 32'(a), 1);
      chk("tp_valid", 32'(bus.out_valid), 1);
    end
    drive(0, 0, 0, 1, 0, a);
    chk("tp_empty", 32'(bus.out_valid), 0);
    drive(1, 3, 0, 1, 0, a);
    chk("ill_sel_data", bus.out_data, 0);
    chk("ill_sel_err", 32'(bus.err), 1);
    drive(1, 0, 0, 1, 0, a);
    chk("err_sticky", 32'(bus.err), 1);
    drive(1, 1, 3'b110, 1, 0, a);
    chk("ill_mode_data", bus.out_data, src[1]);
    drive(0, 0, 0, 1, 1, a);
    chk("flush_err", 32'(bus.err), 0);
    chk("flush_valid", 32'(bus.out_valid), 0);
    drive(1, 0, 0, 0, 0, a);
    drive(1, 1, 0, 0, 0, a);
    drive(1, 2, 0, 1, 1, a);
    chk("flush2_valid", 32'(bus.out_valid), 0);
    chk("flush2_ready", 32'(bus.in_ready), 1);
    drive(1, 0, 0, 0, 0, a);
    drive(1, 1, 3'b110, 1, 1, a);
    chk("flush_acc_err", 32'(bus.err), 0);
    chk("flush_acc_valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < 400; i++) begin
      foreach (src[j]) src[j] = $urandom;
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, a);
      if (i == 200) begin
        bus.in_valid = 1;
        reset_n = 0;
        q.delete();
        exp_err = 0;
        #1 chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_err", 32'(bus.err), 0);
        @(posedge clk);
        #1 reset_n = 1;
      end
    end
    repeat (3) drive(0, 0, 0, 1, 0, a);
    chk("end_empty", 32'(bus.out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
